// File: rtl/edge_counter_array_if.sv
`default_nettype none
// ============================================================================
// Module      : edge_counter_array_if
// Description : Register-map side bundle for edge_counter_array: channel
//               inputs, per-channel configuration, readback select/data and
//               channel status.
//               Optional macro EDGE_COUNTER_ARRAY_OVF_EN adds the ovf status.
// Revision    : 1.0 - initial release
// ============================================================================
interface edge_counter_array_if #(
  parameter int NUM_CH    = 4,
  parameter int NUM_EDGES = 3,
  parameter int CNT_W     = 32
);
  localparam int c_CH_W  = (NUM_CH    > 1) ? $clog2(NUM_CH)    : 1;
  localparam int c_IDX_W = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1;

  logic [NUM_CH-1:0]  gpio_in;
  logic [NUM_CH-1:0]  cfg_enable;
  logic [NUM_CH-1:0]  cfg_in_inv;
  logic [NUM_CH-1:0]  cfg_trig_enable;
  logic [NUM_CH-1:0]  cfg_trig_out;
  logic [c_CH_W-1:0]  rd_ch;
  logic [c_IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0]   rd_data;
  logic [NUM_CH-1:0]  busy;
  logic [NUM_CH-1:0]  done;
`ifdef EDGE_COUNTER_ARRAY_OVF_EN
  logic [NUM_CH-1:0]  ovf;
`endif

  // Register map / bench side
  modport master (
    output gpio_in, cfg_enable, cfg_in_inv, cfg_trig_enable, cfg_trig_out,
    output rd_ch, rd_idx,
`ifdef EDGE_COUNTER_ARRAY_OVF_EN
    input  ovf,
`endif
    input  rd_data, busy, done
  );

  // Timer array side
  modport slave (
    input  gpio_in, cfg_enable, cfg_in_inv, cfg_trig_enable, cfg_trig_out,
    input  rd_ch, rd_idx,
`ifdef EDGE_COUNTER_ARRAY_OVF_EN
    output ovf,
`endif
    output rd_data, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/edge_counter_array.sv
`default_nettype none
// ============================================================================
// Module      : edge_counter_array
// Description : NUM_CH-channel edge-duration timer. Each channel synchronises
//               one gpio input, times NUM_EDGES intervals between consecutive
//               edges, and can be started by its ring predecessor's trigger.
//               Optional macro EDGE_COUNTER_ARRAY_OVF_EN adds a sticky
//               per-channel saturation flag (ovf).
// Revision    : 1.0 - initial release
// ============================================================================
module edge_counter_array #(
  parameter int NUM_CH    = 4,
  parameter int NUM_EDGES = 3,
  parameter int CNT_W     = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_sync,
  edge_counter_array_if.slave bus
);
  localparam int c_CH_W  = (NUM_CH    > 1) ? $clog2(NUM_CH)    : 1;
  localparam int c_IDX_W = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1;
  // Write index must be able to step one past the last slot
  localparam int c_IW    = $clog2(NUM_EDGES + 1);
  localparam logic [c_IW-1:0]  c_LAST = c_IW'(NUM_EDGES - 1);
  localparam logic [CNT_W-1:0] c_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  logic [NUM_CH-1:0] w_trig;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_done;
  logic [CNT_W-1:0]  w_ch_rd [NUM_CH];
  logic [CNT_W-1:0]  r_rd_data;
`ifdef EDGE_COUNTER_ARRAY_OVF_EN
  logic [NUM_CH-1:0] w_ovf;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int c_PRED = (i + NUM_CH - 1) % NUM_CH;

    logic             r_sync1, r_sync2, r_s_prev, r_en_prev;
    logic             r_trig, r_busy, r_done;
    logic             w_s, w_edge, w_start, w_en_rise;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt, w_cnt_inc, w_rd_sel;
    logic [c_IW-1:0]  r_idx;
    logic [CNT_W-1:0] r_dur [NUM_EDGES];

    assign w_s       = r_sync2 ^ bus.cfg_in_inv[i];
    assign w_edge    = w_s ^ r_s_prev;
    assign w_start   = w_edge | (bus.cfg_trig_enable[i] & w_trig[c_PRED]);
    assign w_en_rise = bus.cfg_enable[i] & ~r_en_prev;
    // Counter clamps at all-ones instead of wrapping
    assign w_cnt_inc = (r_cnt == c_MAX) ? c_MAX : r_cnt + CNT_W'(1);

    // Two-flop synchroniser plus previous-level and previous-enable history
    always_ff @(posedge clk) begin
      if (rst_sync) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_s_prev  <= 1'b0;
        r_en_prev <= 1'b0;
      end else begin
        r_sync1   <= bus.gpio_in[i];
        r_sync2   <= r_sync1;
        r_s_prev  <= w_s;
        r_en_prev <= bus.cfg_enable[i];
      end
    end

    // Channel FSM: arm on enable rise, start on edge/trigger, store durations
    always_ff @(posedge clk) begin
      if (rst_sync) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_trig  <= 1'b0;
        for (int e = 0; e < NUM_EDGES; e++) r_dur[e] <= '0;
      end else if (!bus.cfg_enable[i]) begin
        // Durations and index are kept so results remain readable
        r_state <= S_IDLE;
        r_trig  <= 1'b0;
      end else begin
        r_trig <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_en_rise) begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= S_ARMED;
              for (int e = 0; e < NUM_EDGES; e++) r_dur[e] <= '0;
            end
          end
          S_ARMED: begin
            // A coincident own edge is consumed as the start only
            if (w_start) begin
              r_cnt   <= '0;
              r_trig  <= bus.cfg_trig_out[i];
              r_state <= S_COUNT;
            end
          end
          S_COUNT: begin
            if (w_edge) begin
              for (int e = 0; e < NUM_EDGES; e++)
                if (r_idx == c_IW'(e)) r_dur[e] <= w_cnt_inc;
              r_cnt <= '0;
              r_idx <= r_idx + c_IW'(1);
              if (r_idx == c_LAST) r_state <= S_DONE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_DONE:  r_state <= S_DONE;
          default: r_state <= S_IDLE;
        endcase
      end
    end

    // Status flags are registered decodes of the current state
    always_ff @(posedge clk) begin
      if (rst_sync) begin
        r_busy <= 1'b0;
        r_done <= 1'b0;
      end else begin
        r_busy <= (r_state == S_ARMED) || (r_state == S_COUNT);
        r_done <= (r_state == S_DONE);
      end
    end

`ifdef EDGE_COUNTER_ARRAY_OVF_EN
    logic r_ovf;
    // Sticky flag: a clamp occurs whenever a counting channel sits at all-ones
    always_ff @(posedge clk) begin
      if (rst_sync || w_en_rise)
        r_ovf <= 1'b0;
      else if (bus.cfg_enable[i] && (r_state == S_COUNT) && (r_cnt == c_MAX))
        r_ovf <= 1'b1;
    end
    assign w_ovf[i] = r_ovf;
`endif

    // Per-channel duration select; out-of-range index reads as zero
    always_comb begin
      w_rd_sel = '0;
      for (int e = 0; e < NUM_EDGES; e++)
        if (bus.rd_idx == c_IDX_W'(e)) w_rd_sel = r_dur[e];
    end

    assign w_ch_rd[i] = w_rd_sel;
    assign w_trig[i]  = r_trig;
    assign w_busy[i]  = r_busy;
    assign w_done[i]  = r_done;
  end : g_ch

  // Registered readback; out-of-range channel reads as zero
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= '0;
      for (int c = 0; c < NUM_CH; c++)
        if (bus.rd_ch == c_CH_W'(c)) r_rd_data <= w_ch_rd[c];
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
`ifdef EDGE_COUNTER_ARRAY_OVF_EN
  assign bus.ovf     = w_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_counter_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_counter_array
// Description : Directed self-checking bench for edge_counter_array. DUT A
//               uses default parameters; DUT B (3 ch, 3 edges, 4-bit) covers
//               saturation and out-of-range readback.
//               Optional macro EDGE_COUNTER_ARRAY_OVF_EN enables ovf checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_counter_array;
  logic clk;
  logic rst_sync;

  int n_cmp = 0;
  int n_err = 0;

  edge_counter_array_if #(.NUM_CH(4), .NUM_EDGES(3), .CNT_W(32)) ifa ();
  edge_counter_array_if #(.NUM_CH(3), .NUM_EDGES(3), .CNT_W(4))  ifb ();

  edge_counter_array #(.NUM_CH(4), .NUM_EDGES(3), .CNT_W(32)) u_dut_a (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (ifa)
  );

  edge_counter_array #(.NUM_CH(3), .NUM_EDGES(3), .CNT_W(4)) u_dut_b (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     sel;   // 0 = DUT A, 1 = DUT B
    int     ch;
    int     idx;
    longint exp;
  } rb_vec_t;

  rb_vec_t tbl [13];

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input bit sel, input int ch, input int idx,
                        input longint exp);
    if (sel) begin
      ifb.rd_ch  = 2'(ch);
      ifb.rd_idx = 2'(idx);
    end else begin
      ifa.rd_ch  = 2'(ch);
      ifa.rd_idx = 2'(idx);
    end
    tick(1);
    chk(name, sel ? 64'(ifb.rd_data) : 64'(ifa.rd_data), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed readback vectors
    tbl[0]  = '{0, 0, 0, 10};
    tbl[1]  = '{0, 0, 1, 25};
    tbl[2]  = '{0, 0, 2, 50};
    tbl[3]  = '{0, 1, 0, 0};
    tbl[4]  = '{0, 3, 2, 0};
    tbl[5]  = '{0, 0, 3, 0};
    tbl[6]  = '{0, 0, 1, 25};
    tbl[7]  = '{1, 0, 0, 15};
    tbl[8]  = '{1, 0, 1, 15};
    tbl[9]  = '{1, 0, 2, 15};
    tbl[10] = '{1, 3, 0, 0};
    tbl[11] = '{1, 0, 3, 0};
    tbl[12] = '{1, 1, 1, 0};

    ifa.gpio_in = '0; ifa.cfg_enable = '0; ifa.cfg_in_inv = '0;
    ifa.cfg_trig_enable = '0; ifa.cfg_trig_out = '0; ifa.rd_ch = '0; ifa.rd_idx = '0;
    ifb.gpio_in = '0; ifb.cfg_enable = '0; ifb.cfg_in_inv = '0;
    ifb.cfg_trig_enable = '0; ifb.cfg_trig_out = '0; ifb.rd_ch = '0; ifb.rd_idx = '0;
    rst_sync = 1'b1;
    tick(3);
    rst_sync = 1'b0;
    tick(1);

    // Reset state
    chk("reset_busy", 64'(ifa.busy), 0);
    chk("reset_done", 64'(ifa.done), 0);
    chk("reset_rd",   64'(ifa.rd_data), 0);

    // Saturation on DUT B: edges 20 cycles apart with a 4-bit counter
    ifb.cfg_enable = 3'b001;
    tick(3);
    for (int t = 0; t <= 70; t++) begin
      if (t == 0 || t == 20 || t == 40 || t == 60) ifb.gpio_in[0] = ~ifb.gpio_in[0];
`ifdef EDGE_COUNTER_ARRAY_OVF_EN
      if (t == 10) chk("ovf_pre", 64'(ifb.ovf[0]), 0);
`endif
      tick(1);
    end
    chk("sat_done", 64'(ifb.done[0]), 1);
`ifdef EDGE_COUNTER_ARRAY_OVF_EN
    chk("ovf_set", 64'(ifb.ovf[0]), 1);
`endif

    // Basic: toggles at 0, 10, 35, 85 give 10, 25, 50; done at toggle+4
    ifa.cfg_enable = 4'b0001;
    tick(3);
    chk("basic_busy", 64'(ifa.busy), 1);
    for (int t = 0; t <= 90; t++) begin
      if (t == 0 || t == 10 || t == 35 || t == 85) ifa.gpio_in[0] = ~ifa.gpio_in[0];
      if (t == 88) chk("basic_done_early", 64'(ifa.done[0]), 0);
      if (t == 89) chk("basic_done_edge4", 64'(ifa.done[0]), 1);
      tick(1);
    end
    chk("basic_busy_off", 64'(ifa.busy[0]), 0);

    // Table-driven readback across both DUTs
    for (int k = 0; k < 13; k++)
      rd_chk($sformatf("rb%0d", k), tbl[k].sel, tbl[k].ch, tbl[k].idx, tbl[k].exp);

`ifdef EDGE_COUNTER_ARRAY_OVF_EN
    ifb.cfg_enable = 3'b000;
    tick(2);
    ifb.cfg_enable = 3'b001;
    tick(2);
    chk("ovf_clear", 64'(ifb.ovf[0]), 0);
`endif

    // Disable keeps durations; re-enable clears them and arms
    ifa.cfg_enable = 4'b0000;
    tick(2);
    chk("dis_busy", 64'(ifa.busy), 0);
    chk("dis_done", 64'(ifa.done), 0);
    rd_chk("dis_keep", 0, 0, 1, 25);
    ifa.cfg_enable = 4'b0001;
    tick(3);
    chk("rearm_busy", 64'(ifa.busy[0]), 1);
    rd_chk("rearm_d0", 0, 0, 0, 0);
    rd_chk("rearm_d2", 0, 0, 2, 0);

    // Trigger chain: ch0 starts at T, ch1 at T+1, ch2 at T+2
    ifa.cfg_enable      = 4'b0000;
    ifa.cfg_trig_out    = 4'b0111;
    ifa.cfg_trig_enable = 4'b0110;
    tick(2);
    ifa.cfg_enable = 4'b0111;
    tick(3);
    for (int t = 0; t <= 40; t++) begin
      if (t == 0 || t == 25) ifa.gpio_in[0] = ~ifa.gpio_in[0];
      if (t == 20) ifa.gpio_in[1] = ~ifa.gpio_in[1];
      if (t == 30) ifa.gpio_in[2] = ~ifa.gpio_in[2];
      tick(1);
    end
    rd_chk("chain_ch0", 0, 0, 0, 25);
    rd_chk("chain_ch1", 0, 1, 0, 19);
    rd_chk("chain_ch2", 0, 2, 0, 28);
    chk("chain_ch3_idle", 64'(ifa.busy[3]), 0);

    // Coincident trigger + own edge on ch1; inverted static input on ch2
    ifa.cfg_enable      = 4'b0000;
    ifa.cfg_trig_out    = 4'b0001;
    ifa.cfg_trig_enable = 4'b0010;
    ifa.cfg_in_inv      = 4'b0100;
    tick(4);
    ifa.cfg_enable = 4'b0111;
    tick(3);
    for (int t = 0; t <= 25; t++) begin
      if (t == 0) ifa.gpio_in[0] = ~ifa.gpio_in[0];
      if (t == 1 || t == 11) ifa.gpio_in[1] = ~ifa.gpio_in[1];
      if (t == 10) chk("inv_armed", 64'(ifa.busy[2]), 1);
      if (t == 20) ifa.gpio_in[2] = ~ifa.gpio_in[2];
      tick(1);
    end
    rd_chk("coinc_d0", 0, 1, 0, 10);
    rd_chk("coinc_d1", 0, 1, 1, 0);
    rd_chk("inv_nostart", 0, 2, 0, 0);

    // Reset while counting clears every output next cycle
    rd_chk("pre_rst_rd", 0, 1, 0, 10);
    rst_sync = 1'b1;
    tick(1);
    chk("rst_busy", 64'(ifa.busy), 0);
    chk("rst_done", 64'(ifa.done), 0);
    chk("rst_rd",   64'(ifa.rd_data), 0);
    rst_sync = 1'b0;
    tick(2);
    rd_chk("rst_dur_clr", 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
